ifetch_ctrl: RTL and testbench

//  Instruction-fetch controller: consumer of the PC register's address output.

---
 rtl/ifetch_ctrl.sv | 150 +++++++++++++++
 tb/tb_ifetch_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: req/gnt/rvalid read of the word at pc_addr, holds it for decode.
// Optional fetch timeout guarded by `FETCH_TIMEOUT_EN (sticky fetch_err, NOP delivered).
module ifetch_ctrl #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                TIMEOUT   = 16,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              fetch_en,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ack,
    output logic              pc_stall,
    output logic              fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] instr_n;
    logic              valid_n;
    logic              timeout_fire;
    logic [ADDR_W-1:0] aligned_pc;

    assign aligned_pc = {pc_addr[ADDR_W-1:2], 2'b00};

    logic unused_pc_lsb;
    assign unused_pc_lsb = ^pc_addr[1:0];

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_cnt;
    logic             in_fetch;

    assign in_fetch     = (state == S_REQ) || (state == S_WAIT);
    assign timeout_fire = in_fetch && !flush && (tmo_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt   <= '0;
            fetch_err <= 1'b0;
        end else begin
            if (state_n == S_REQ && state != S_REQ)
                tmo_cnt <= '0;
            else if (in_fetch)
                tmo_cnt <= tmo_cnt + 1'b1;
            if (timeout_fire)
                fetch_err <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_fire   = 1'b0;
    assign fetch_err      = 1'b0;
`endif

    always_comb begin
        state_n = state;
        addr_n  = imem_addr;
        instr_n = instr;
        valid_n = instr_valid;
        case (state)
            S_IDLE: begin
                if (fetch_en && !flush) begin
                    state_n = S_REQ;
                    addr_n  = aligned_pc;
                end
            end
            S_REQ: begin
                // a granted request still owes one rvalid, so a flush must drain it
                if (flush)
                    state_n = imem_gnt ? S_DRAIN : S_IDLE;
                else if (timeout_fire) begin
                    state_n = S_HOLD;
                    instr_n = NOP_INSTR;
                    valid_n = 1'b1;
                end else if (imem_gnt)
                    state_n = S_WAIT;
            end
            S_WAIT: begin
                if (flush)
                    state_n = imem_rvalid ? S_IDLE : S_DRAIN;
                else if (timeout_fire) begin
                    state_n = S_HOLD;
                    instr_n = NOP_INSTR;
                    valid_n = 1'b1;
                end else if (imem_rvalid) begin
                    state_n = S_HOLD;
                    instr_n = imem_rdata;
                    valid_n = 1'b1;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    state_n = S_IDLE;
                    valid_n = 1'b0;
                end else if (instr_ack) begin
                    valid_n = 1'b0;
                    if (fetch_en) begin
                        state_n = S_REQ;
                        addr_n  = aligned_pc;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (imem_rvalid)
                    state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            imem_addr   <= '0;
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_n;
            imem_addr   <= addr_n;
            instr       <= instr_n;
            instr_valid <= valid_n;
        end
    end

    assign imem_req = (state == S_REQ);
    // the PC moves exactly on the cycle decode takes the held word
    assign pc_stall = !((state == S_HOLD) && instr_ack && !flush);

endmodule

// File: tb/tb_ifetch_ctrl.sv
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_addr;
    logic        fetch_en, flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid, instr_ack, pc_stall, fetch_err;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] sb_q[$];

    ifetch_ctrl #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .NOP_INSTR(32'h0)
    ) dut (
        .clk(clk), .rst(rst), .pc_addr(pc_addr), .fetch_en(fetch_en), .flush(flush),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr),
        .instr_valid(instr_valid), .instr_ack(instr_ack), .pc_stall(pc_stall),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // inputs change on the falling edge; outputs are checked 1 time unit later
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic pop_chk(input string tag);
        logic [31:0] exp;
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s_sb: observed output %h expected empty scoreboard", tag, instr);
        end else begin
            exp = sb_q.pop_front();
            chk({tag, "_instr"}, instr, exp);
        end
    endtask

    // starts a fetch from IDLE; returns in the first REQ cycle (inputs idle)
    task automatic start_fetch(input logic [31:0] pc);
        cyc(); pc_addr = pc; fetch_en = 1'b1;
        cyc(); fetch_en = 1'b0; settle();
    endtask

    initial begin
        int req_cycles;
        rst = 1'b0; pc_addr = 32'h1234_5678; fetch_en = 1'b1; flush = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'hFFFF_FFFF; instr_ack = 1'b0;

        // reset holds everything quiet even with fetch_en high
        repeat (3) cyc();
        settle();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_stall", {31'd0, pc_stall}, 32'd1);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        cyc(); rst = 1'b1; fetch_en = 1'b0;

        // basic zero-wait fetch and single PC advance on ack
        start_fetch(32'h0040_0000);
        chk("t2_req", {31'd0, imem_req}, 32'd1);
        chk("t2_addr", imem_addr, 32'h0040_0000);
        imem_gnt = 1'b1;
        cyc(); imem_gnt = 1'b0; settle();
        chk("t2_req_wait", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'h2008_0005; sb_q.push_back(32'h2008_0005);
        cyc(); imem_rvalid = 1'b0; imem_rdata = 32'hFFFF_FFFF; settle();
        pop_chk("t2");
        chk("t2_stall_noack", {31'd0, pc_stall}, 32'd1);
        instr_ack = 1'b1; settle();
        chk("t2_stall_ack", {31'd0, pc_stall}, 32'd0);
        cyc(); instr_ack = 1'b0; settle();
        chk("t2_stall_after", {31'd0, pc_stall}, 32'd1);
        chk("t2_valid_after", {31'd0, instr_valid}, 32'd0);

        // delayed grant, delayed rvalid
        start_fetch(32'h0040_0020);
        req_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (imem_req) req_cycles++;
            chk("t3_addr_stable", imem_addr, 32'h0040_0020);
            if (i == 3) imem_gnt = 1'b1;
            if (i < 3) begin cyc(); settle(); end
        end
        cyc(); imem_gnt = 1'b0; settle();
        chk("t3_req_cycles", req_cycles, 32'd4);
        chk("t3_req_low", {31'd0, imem_req}, 32'd0);
        cyc(); settle();
        chk("t3_valid_early", {31'd0, instr_valid}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hA5A5_0001; sb_q.push_back(32'hA5A5_0001);
        cyc(); imem_rvalid = 1'b0; settle();
        pop_chk("t3");
        // ack with fetch_en goes straight back to REQ on the new PC
        instr_ack = 1'b1; fetch_en = 1'b1; pc_addr = 32'h0040_0040;
        cyc(); instr_ack = 1'b0; fetch_en = 1'b0; settle();
        chk("t3_b2b_req", {31'd0, imem_req}, 32'd1);
        chk("t3_b2b_addr", imem_addr, 32'h0040_0040);
        chk("t3_b2b_valid", {31'd0, instr_valid}, 32'd0);
        imem_gnt = 1'b1;
        cyc(); imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0BB0; sb_q.push_back(32'h0000_0BB0);
        cyc(); imem_rvalid = 1'b0; settle();
        pop_chk("t3b");
        instr_ack = 1'b1;
        cyc(); instr_ack = 1'b0;

        // flush in WAIT: late data is drained, never delivered
        start_fetch(32'h0040_0030);
        imem_gnt = 1'b1;
        cyc(); imem_gnt = 1'b0; flush = 1'b1;
        cyc(); flush = 1'b0;
        cyc(); imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        cyc(); imem_rvalid = 1'b0; settle();
        chk("t4_valid", {31'd0, instr_valid}, 32'd0);
        chk("t4_req", {31'd0, imem_req}, 32'd0);
        start_fetch(32'h0040_0010);
        chk("t4_req2", {31'd0, imem_req}, 32'd1);
        chk("t4_addr2", imem_addr, 32'h0040_0010);
        imem_gnt = 1'b1;
        cyc(); imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111; sb_q.push_back(32'h1111_1111);
        cyc(); imem_rvalid = 1'b0; settle();
        pop_chk("t4");
        instr_ack = 1'b1;
        cyc(); instr_ack = 1'b0;

        // unaligned PC, flush beating ack in HOLD
        start_fetch(32'h0040_0006);
        chk("t5_addr", imem_addr, 32'h0040_0004);
        imem_gnt = 1'b1;
        cyc(); imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h0C0F_FEE0; sb_q.push_back(32'h0C0F_FEE0);
        cyc(); imem_rvalid = 1'b0; settle();
        pop_chk("t5");
        instr_ack = 1'b1; flush = 1'b1; settle();
        chk("t5_stall_flush", {31'd0, pc_stall}, 32'd1);
        cyc(); instr_ack = 1'b0; flush = 1'b0; settle();
        chk("t5_valid", {31'd0, instr_valid}, 32'd0);
        chk("t5_req", {31'd0, imem_req}, 32'd0);
        // stray rvalid/gnt in IDLE are ignored
        imem_rvalid = 1'b1; imem_gnt = 1'b1; imem_rdata = 32'h7777_7777;
        cyc(); imem_rvalid = 1'b0; imem_gnt = 1'b0; settle();
        chk("t5_idle_rvalid", {31'd0, instr_valid}, 32'd0);
        chk("t5_idle_gnt", {31'd0, imem_req}, 32'd0);

        // flush coincident with gnt in REQ drains the owed response
        start_fetch(32'h0040_0050);
        imem_gnt = 1'b1; flush = 1'b1;
        cyc(); imem_gnt = 1'b0; flush = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h5555_AAAA;
        cyc(); imem_rvalid = 1'b0; settle();
        chk("t5_drain_valid", {31'd0, instr_valid}, 32'd0);
        chk("t5_drain_req", {31'd0, imem_req}, 32'd0);

`ifdef FETCH_TIMEOUT_EN
        // grant never comes: REQ lasts TIMEOUT cycles, then a sticky error with NOP
        start_fetch(32'h0040_0060);
        req_cycles = 0;
        for (int i = 0; i < 20 && imem_req; i++) begin
            req_cycles++;
            cyc(); settle();
        end
        chk("t6_req_cycles", req_cycles, 32'd4);
        chk("t6_err", {31'd0, fetch_err}, 32'd1);
        chk("t6_instr", instr, 32'h0);
        chk("t6_valid", {31'd0, instr_valid}, 32'd1);
        instr_ack = 1'b1;
        cyc(); instr_ack = 1'b0;
        repeat (3) cyc();
        settle();
        chk("t6_err_sticky", {31'd0, fetch_err}, 32'd1);
        rst = 1'b0; settle();
        chk("t6_err_rst", {31'd0, fetch_err}, 32'd0);
        cyc(); rst = 1'b1;
`else
        // without the timeout the fetch waits indefinitely
        start_fetch(32'h0040_0060);
        repeat (20) cyc();
        settle();
        chk("t6_wait_req", {31'd0, imem_req}, 32'd1);
        chk("t6_no_err", {31'd0, fetch_err}, 32'd0);
        chk("t6_no_valid", {31'd0, instr_valid}, 32'd0);
        flush = 1'b1;
        cyc(); flush = 1'b0;
`endif

        // asynchronous reset mid-fetch
        start_fetch(32'h0040_0070);
        imem_gnt = 1'b1;
        cyc(); imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h1234_ABCD;
        cyc(); imem_rvalid = 1'b0; settle();
        chk("rst2_pre_valid", {31'd0, instr_valid}, 32'd1);
        #2 rst = 1'b0; settle();
        chk("rst2_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst2_instr", instr, 32'h0);
        chk("rst2_stall", {31'd0, pc_stall}, 32'd1);
        chk("rst2_req", {31'd0, imem_req}, 32'd0);
        cyc(); rst = 1'b1;
        cyc();

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL sb_drain: observed %0d leftover entries expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
